cpu_mem_arbiter: RTL and testbench
==================================

CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset, asynchronous, active-low (rst=0 resets).
REQ-003 PC  in  32  CPU instruction fetch address.
REQ-004 Inst_Req_Valid  in  1  CPU instruction request valid.
REQ-005 Inst_Req_Ready  out  1  instruction request accepted.
REQ-006 Instruction  out  32  fetched instruction word.
REQ-007 Inst_Valid  out  1  Instruction valid.
REQ-008 Inst_Ready  in  1  CPU ready to take Instruction.
REQ-009 Address  in  32  CPU data address, word-aligned.
REQ-010 MemWrite  in  1  CPU store request valid.
REQ-011 Write_data  in  32  store data.
REQ-012 Write_strb  in  4  store byte enables.
REQ-013 MemRead  in  1  CPU load request valid.
REQ-014 Mem_Req_Ready  out  1  data request accepted.
REQ-015 Read_data  out  32  load data.
REQ-016 Read_data_Valid  out  1  Read_data valid.
REQ-017 Read_data_Ready  in  1  CPU ready to take Read_data.
REQ-018 mem_addr  out  32  shared memory address (registered).
REQ-019 mem_ren / mem_wen  out  1 each  memory read/write request valid (registered, one-hot or both 0).
REQ-020 mem_wdata / mem_wstrb  out  32/4  registered store data and byte enables.
REQ-021 mem_req_ready  in  1  memory accepts request when high with mem_ren|mem_wen.
REQ-022 mem_rdata / mem_rvalid  in  32/1  memory read response.
REQ-023 mem_rready  out  1  arbiter ready for read response.

Function
REQ-024 States SHALL be IDLE, REQ, RSP, OUT; one transaction outstanding; kind latched as INST, LOAD, STORE.
REQ-025 IDLE: Inst_Req_Ready, Mem_Req_Ready and Mem_Req_Ready are combinational grants; at most one high per cycle.
REQ-026 Priority in IDLE: data (MemRead or MemWrite) over Inst_Req_Valid; MemWrite over MemRead if both are asserted.
REQ-027 On grant, capture addr/wdata/wstrb/kind and go to REQ; mem_* valid rises the next cycle (1-cycle latency).
REQ-028 REQ: hold mem_* stable until mem_req_ready; then STORE -> IDLE, INST/LOAD -> RSP.
REQ-029 RSP: mem_rready=1; on mem_rvalid capture mem_rdata into a 32-bit buffer -> OUT.
REQ-030 OUT: drive buffer on Instruction (INST) or Read_data (LOAD) with matching valid; hold until the CPU ready signal is high, then -> IDLE.
REQ-031 The response valid SHALL NOT be asserted for the wrong channel; Instruction and Read_data SHALL both show the buffer value.
REQ-032 No new grant SHALL occur while not in IDLE; minimum INST/LOAD round trip is 4 cycles with zero memory wait.
REQ-033 CPU request signals that drop before grant SHALL be ignored without error.

Reset
REQ-034 rst low, including mid-transaction: state=IDLE; all valid/ready outputs, mem_ren, mem_wen and mem_rready=0; mem_addr, mem_wdata, mem_wstrb, buffer and kind=0.
REQ-035 After rst rises, the first grant SHALL occur no earlier than the first posedge.

Verification
REQ-036 Fetch PC=0x100, mem_req_ready=1, mem_rvalid one cycle later with 0x00000013 -> mem_addr=0x100 and mem_ren=1 for 1 cycle; Inst_Valid=1 with Instruction=0x00000013; no Read_data_Valid.
REQ-037 Store Address=0x200, Write_data=0xDEADBEEF, strb=4'b0011, mem_req_ready low 3 cycles -> mem_wen stays high with stable fields for 4 cycles, then returns to IDLE; no response valid.
REQ-038 Simultaneous MemRead at 0x40 and Inst_Req_Valid at 0x8 -> Mem_Req_Ready granted first and load completes; fetch is granted only after OUT exits.
REQ-039 Load response 0x12345678 with Read_data_Ready low 5 cycles -> Read_data_Valid stays high and the value holds for 5 cycles; exits on the ready cycle.
REQ-040 rst pulled low in RSP -> all outputs return to 0 immediately (asynchronously); a later mem_rvalid is ignored and no Inst_Valid is issued.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_mem_arbiter
// Shares one memory port between a CPU instruction-fetch channel and a CPU
// data (load/store) channel. Only one transaction is outstanding at a time.
// Data requests win over fetches. A store wins over a load.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   PC / Inst_Req_Valid / Inst_Req_Ready
//                            fetch request channel (ready is a grant)
//   Instruction / Inst_Valid / Inst_Ready
//                            fetch response channel
//   Address / MemWrite / Write_data / Write_strb / MemRead / Mem_Req_Ready
//                            data request channel (ready is a grant)
//   Read_data / Read_data_Valid / Read_data_Ready
//                            load response channel
//   mem_addr / mem_ren / mem_wen / mem_wdata / mem_wstrb / mem_req_ready
//                            registered request to memory
//   mem_rdata / mem_rvalid / mem_rready
//                            memory read response
// ---------------------------------------------------------------------------
module cpu_mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   // instruction fetch
   input  logic [31:0] PC,
   input  logic        Inst_Req_Valid,
   output logic        Inst_Req_Ready,
   output logic [31:0] Instruction,
   output logic        Inst_Valid,
   input  logic        Inst_Ready,
   // data access
   input  logic [31:0] Address,
   input  logic        MemWrite,
   input  logic [31:0] Write_data,
   input  logic [3:0]  Write_strb,
   input  logic        MemRead,
   output logic        Mem_Req_Ready,
   output logic [31:0] Read_data,
   output logic        Read_data_Valid,
   input  logic        Read_data_Ready,
   // memory side
   output logic [31:0] mem_addr,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_req_ready,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        mem_rready
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   // KIND_NONE is the reset value; a real transaction always overwrites it.
   localparam logic [1:0] KIND_NONE  = 2'd0;
   localparam logic [1:0] KIND_INST  = 2'd1;
   localparam logic [1:0] KIND_LOAD  = 2'd2;
   localparam logic [1:0] KIND_STORE = 2'd3;

   state_t      state_r;
   state_t      state_next_s;
   logic [1:0]  kind_r;
   logic [31:0] buf_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [3:0]  wstrb_r;
   logic        ren_r;
   logic        wen_r;

   logic        grant_data_s;
   logic        grant_inst_s;
   logic        inst_valid_s;
   logic        rd_valid_s;
   logic        rready_s;
   logic        out_taken_s;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      out_taken_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (grant_data_s || grant_inst_s) begin
               state_next_s = ST_REQ;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (mem_req_ready) begin
               if (kind_r == KIND_STORE) begin
                  state_next_s = ST_IDLE;
               end else begin
                  state_next_s = ST_RSP;
               end
            end else begin
               state_next_s = ST_REQ;
            end
         end
         ST_RSP: begin
            if (mem_rvalid) begin
               state_next_s = ST_OUT;
            end else begin
               state_next_s = ST_RSP;
            end
         end
         ST_OUT: begin
            out_taken_s = ((kind_r == KIND_INST) && Inst_Ready) ||
                          ((kind_r == KIND_LOAD) && Read_data_Ready);
            if (out_taken_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_OUT;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Output decode: grants in IDLE, read-ready in RSP, response valid in OUT.
   // Grants are gated with rst so nothing is offered while reset is held.
   always_comb begin
      grant_data_s = 1'b0;
      grant_inst_s = 1'b0;
      rready_s     = 1'b0;
      inst_valid_s = 1'b0;
      rd_valid_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            grant_data_s = rst & (MemRead | MemWrite);
            grant_inst_s = rst & ~(MemRead | MemWrite) & Inst_Req_Valid;
         end
         ST_REQ: begin
            rready_s = 1'b0;
         end
         ST_RSP: begin
            rready_s = 1'b1;
         end
         ST_OUT: begin
            inst_valid_s = (kind_r == KIND_INST);
            rd_valid_s   = (kind_r == KIND_LOAD);
         end
         default: begin
            rready_s = 1'b0;
         end
      endcase
   end

   // Transaction capture, memory request valids and response buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kind_r  <= KIND_NONE;
         buf_r   <= 32'd0;
         addr_r  <= 32'd0;
         wdata_r <= 32'd0;
         wstrb_r <= 4'd0;
         ren_r   <= 1'b0;
         wen_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_data_s) begin
                  addr_r  <= Address;
                  kind_r  <= MemWrite ? KIND_STORE : KIND_LOAD;
                  wdata_r <= MemWrite ? Write_data : 32'd0;
                  wstrb_r <= MemWrite ? Write_strb : 4'd0;
                  wen_r   <= MemWrite;
                  ren_r   <= ~MemWrite;
               end else if (grant_inst_s) begin
                  addr_r  <= PC;
                  kind_r  <= KIND_INST;
                  wdata_r <= 32'd0;
                  wstrb_r <= 4'd0;
                  wen_r   <= 1'b0;
                  ren_r   <= 1'b1;
               end
            end
            ST_REQ: begin
               // Fields stay stable until the memory takes the request.
               if (mem_req_ready) begin
                  ren_r <= 1'b0;
                  wen_r <= 1'b0;
               end
            end
            ST_RSP: begin
               if (mem_rvalid) begin
                  buf_r <= mem_rdata;
               end
            end
            ST_OUT: begin
               buf_r <= buf_r;
            end
            default: begin
               ren_r <= 1'b0;
               wen_r <= 1'b0;
            end
         endcase
      end
   end

   assign Inst_Req_Ready  = grant_inst_s;
   assign Mem_Req_Ready   = grant_data_s;
   assign Instruction     = buf_r;
   assign Read_data       = buf_r;
   assign Inst_Valid      = inst_valid_s;
   assign Read_data_Valid = rd_valid_s;
   assign mem_addr        = addr_r;
   assign mem_ren         = ren_r;
   assign mem_wen         = wen_r;
   assign mem_wdata       = wdata_r;
   assign mem_wstrb       = wstrb_r;
   assign mem_rready      = rready_s;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_arbiter
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a transaction-level model of the arbiter (one outstanding
// transaction moving through request, response and hand-off phases).
// ---------------------------------------------------------------------------
module tb_cpu_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PC;
   logic        Inst_Req_Valid;
   logic        Inst_Req_Ready;
   logic [31:0] Instruction;
   logic        Inst_Valid;
   logic        Inst_Ready;
   logic [31:0] Address;
   logic        MemWrite;
   logic [31:0] Write_data;
   logic [3:0]  Write_strb;
   logic        MemRead;
   logic        Mem_Req_Ready;
   logic [31:0] Read_data;
   logic        Read_data_Valid;
   logic        Read_data_Ready;
   logic [31:0] mem_addr;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_req_ready;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic        mem_rready;

   always #5 clk = ~clk;

   cpu_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
      .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
      .Address(Address), .MemWrite(MemWrite), .Write_data(Write_data),
      .Write_strb(Write_strb), .MemRead(MemRead), .Mem_Req_Ready(Mem_Req_Ready),
      .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
      .Read_data_Ready(Read_data_Ready),
      .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_req_ready(mem_req_ready),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model: kind 0 = fetch, 1 = load, 2 = store.
   bit          m_busy, m_req_pend, m_rsp_pend, m_out_pend;
   int          m_kind;
   logic [31:0] m_addr, m_wdata, m_data;
   logic [3:0]  m_wstrb;
   int          grant_log[$];
   int          cnt_ren, cnt_wen, cnt_iv, cnt_rv, n_done;

   // Directed-mode CPU/memory behaviour knobs.
   bit want_inst, want_load, want_store, force_rvalid;
   int mem_wait, cpu_wait, wcnt_req, wcnt_out;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h0000_0013;
      else if (a == 32'h0000_0040) return 32'h1234_5678;
      else return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_req_pend = 1'b0; m_rsp_pend = 1'b0; m_out_pend = 1'b0;
      m_kind = 0; m_addr = 32'd0; m_wdata = 32'd0; m_wstrb = 4'd0; m_data = 32'd0;
   endtask

   task automatic clear_counts();
      cnt_ren = 0; cnt_wen = 0; cnt_iv = 0; cnt_rv = 0;
   endtask

   // Called shortly after inputs are driven at the negedge: compare, then
   // advance the model to what the next posedge must produce.
   task automatic sample_and_step();
      bit data_req;
      #1;
      data_req = MemRead | MemWrite;
      check_val("data_grant", 32'(Mem_Req_Ready), 32'(!m_busy && data_req));
      check_val("inst_grant", 32'(Inst_Req_Ready), 32'(!m_busy && !data_req && Inst_Req_Valid));
      check_val("mem_ren", 32'(mem_ren), 32'(m_req_pend && m_kind != 2));
      check_val("mem_wen", 32'(mem_wen), 32'(m_req_pend && m_kind == 2));
      if (m_req_pend) check_val("mem_addr", mem_addr, m_addr);
      if (m_req_pend && m_kind == 2) begin
         check_val("mem_wdata", mem_wdata, m_wdata);
         check_val("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
      end
      check_val("mem_rready", 32'(mem_rready), 32'(m_rsp_pend));
      check_val("inst_valid", 32'(Inst_Valid), 32'(m_out_pend && m_kind == 0));
      check_val("rd_valid", 32'(Read_data_Valid), 32'(m_out_pend && m_kind == 1));
      if (m_out_pend) begin
         check_val("instruction", Instruction, m_data);
         check_val("read_data", Read_data, m_data);
      end
      if (mem_ren === 1'b1) cnt_ren++;
      if (mem_wen === 1'b1) cnt_wen++;
      if (Inst_Valid === 1'b1) cnt_iv++;
      if (Read_data_Valid === 1'b1) cnt_rv++;

      if (m_out_pend) begin
         if ((m_kind == 0 && Inst_Ready) || (m_kind == 1 && Read_data_Ready)) begin
            m_out_pend = 1'b0; m_busy = 1'b0; n_done++;
         end
      end else if (m_rsp_pend) begin
         if (mem_rvalid) begin
            m_rsp_pend = 1'b0; m_out_pend = 1'b1; m_data = mem_rdata;
         end
      end else if (m_req_pend) begin
         if (mem_req_ready) begin
            m_req_pend = 1'b0;
            if (m_kind == 2) begin
               m_busy = 1'b0; n_done++;
            end else begin
               m_rsp_pend = 1'b1;
            end
         end
      end else if (data_req || Inst_Req_Valid) begin
         m_busy = 1'b1; m_req_pend = 1'b1;
         if (MemWrite) begin
            m_kind = 2; m_addr = Address; m_wdata = Write_data; m_wstrb = Write_strb;
            want_store = 1'b0;
         end else if (MemRead) begin
            m_kind = 1; m_addr = Address; want_load = 1'b0;
         end else begin
            m_kind = 0; m_addr = PC; want_inst = 1'b0;
         end
         grant_log.push_back(m_kind);
      end
   endtask

   // Memory and CPU-ready behaviour driven from the model's phase.
   task automatic drive_reactive();
      if (m_req_pend) begin
         mem_req_ready = (wcnt_req >= mem_wait);
         wcnt_req++;
      end else begin
         mem_req_ready = 1'b0;
         wcnt_req = 0;
      end
      mem_rvalid = m_rsp_pend | force_rvalid;
      mem_rdata  = mem_word(m_addr);
      if (m_out_pend) begin
         Inst_Ready      = (wcnt_out >= cpu_wait);
         Read_data_Ready = (wcnt_out >= cpu_wait);
         wcnt_out++;
      end else begin
         Inst_Ready = 1'b0; Read_data_Ready = 1'b0; wcnt_out = 0;
      end
   endtask

   task automatic run_directed(input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         Inst_Req_Valid = want_inst;
         MemRead        = want_load;
         MemWrite       = want_store;
         drive_reactive();
         sample_and_step();
      end
   endtask

   // Used while rst is low: every output must be zero even with requests up.
   task automatic check_all_zero(input string tag);
      MemRead = 1'b1; MemWrite = 1'b1; Inst_Req_Valid = 1'b1;
      #1;
      check_val({tag, "_inst_grant"}, 32'(Inst_Req_Ready), 32'd0);
      check_val({tag, "_data_grant"}, 32'(Mem_Req_Ready), 32'd0);
      check_val({tag, "_valids"}, 32'({Inst_Valid, Read_data_Valid}), 32'd0);
      check_val({tag, "_mem_ctl"}, 32'({mem_ren, mem_wen, mem_rready}), 32'd0);
      check_val({tag, "_mem_addr"}, mem_addr, 32'd0);
      check_val({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check_val({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
      check_val({tag, "_buffer"}, Instruction | Read_data, 32'd0);
      MemRead = 1'b0; MemWrite = 1'b0; Inst_Req_Valid = 1'b0;
   endtask

   initial begin
      int d0;
      rst = 1'b0;
      PC = 32'd0; Inst_Req_Valid = 1'b0; Inst_Ready = 1'b0;
      Address = 32'd0; MemWrite = 1'b0; Write_data = 32'd0; Write_strb = 4'd0;
      MemRead = 1'b0; Read_data_Ready = 1'b0;
      mem_req_ready = 1'b0; mem_rdata = 32'd0; mem_rvalid = 1'b0;
      want_inst = 1'b0; want_load = 1'b0; want_store = 1'b0; force_rvalid = 1'b0;
      mem_wait = 0; cpu_wait = 0; wcnt_req = 0; wcnt_out = 0; n_done = 0;
      model_reset();
      clear_counts();

      // Reset state.
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // Fetch 0x100, zero-wait memory.
      clear_counts(); d0 = n_done;
      PC = 32'h0000_0100; want_inst = 1'b1;
      run_directed(8);
      check_val("fetch_ren_cycles", 32'(cnt_ren), 32'd1);
      check_val("fetch_inst_valid_cycles", 32'(cnt_iv), 32'd1);
      check_val("fetch_no_rd_valid", 32'(cnt_rv), 32'd0);
      check_val("fetch_done", 32'(n_done - d0), 32'd1);

      // Store with memory stalling 3 cycles.
      clear_counts(); d0 = n_done;
      Address = 32'h0000_0200; Write_data = 32'hDEAD_BEEF; Write_strb = 4'b0011;
      want_store = 1'b1; mem_wait = 3;
      run_directed(10);
      check_val("store_wen_cycles", 32'(cnt_wen), 32'd4);
      check_val("store_no_ren", 32'(cnt_ren), 32'd0);
      check_val("store_no_rsp", 32'(cnt_iv + cnt_rv), 32'd0);
      check_val("store_done", 32'(n_done - d0), 32'd1);
      mem_wait = 0;

      // Simultaneous load and fetch: load first, fetch after.
      clear_counts(); grant_log.delete(); d0 = n_done;
      Address = 32'h0000_0040; PC = 32'h0000_0008;
      want_load = 1'b1; want_inst = 1'b1;
      run_directed(14);
      check_val("prio_grants", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() >= 2) begin
         check_val("prio_first_load", 32'(grant_log[0]), 32'd1);
         check_val("prio_then_fetch", 32'(grant_log[1]), 32'd0);
      end
      check_val("prio_done", 32'(n_done - d0), 32'd2);

      // Load with CPU back-pressure for 5 cycles.
      clear_counts(); d0 = n_done;
      Address = 32'h0000_0040; want_load = 1'b1; cpu_wait = 5;
      run_directed(14);
      check_val("bp_rd_valid_cycles", 32'(cnt_rv), 32'd6);
      check_val("bp_done", 32'(n_done - d0), 32'd1);
      cpu_wait = 0;

      // Reset while waiting for the read response.
      clear_counts();
      PC = 32'h0000_0100; want_inst = 1'b1;
      run_directed(2);
      check_val("rst_mid_in_rsp", 32'(m_rsp_pend), 32'd1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      check_all_zero("rst_mid");
      model_reset();
      want_inst = 1'b0;
      force_rvalid = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      run_directed(5);
      check_val("rst_mid_no_inst_valid", 32'(cnt_iv), 32'd0);
      force_rvalid = 1'b0;

      // Random traffic with occasional asynchronous reset.
      d0 = n_done;
      for (int i = 0; i < 3000; i++) begin
         if (i % 700 == 350) begin
            @(posedge clk);
            #2;
            rst = 1'b0;
            check_all_zero("rst_rand");
            model_reset();
            @(negedge clk);
            rst = 1'b1;
         end
         @(negedge clk);
         MemRead         = ($urandom_range(0, 3) == 0);
         MemWrite        = ($urandom_range(0, 4) == 0);
         Inst_Req_Valid  = ($urandom_range(0, 1) == 0);
         PC              = $urandom & 32'hFFFF_FFFC;
         Address         = $urandom & 32'hFFFF_FFFC;
         Write_data      = $urandom;
         Write_strb      = 4'($urandom);
         mem_req_ready   = ($urandom_range(0, 2) != 0);
         mem_rvalid      = ($urandom_range(0, 1) == 0);
         mem_rdata       = $urandom;
         Inst_Ready      = ($urandom_range(0, 1) == 0);
         Read_data_Ready = ($urandom_range(0, 1) == 0);
         sample_and_step();
      end
      check_val("random_progress", 32'(n_done > d0 + 100), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
